// File: rtl/modulo_updown_counter_pkg.sv
// Shared definitions for the modulo up/down counter: direction encoding,
// wrap-flag bundle and the parameter legality check.
package modulo_updown_counter_pkg;

  // Direction encoding on the dir input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Registered wrap pulses, always cleared together.
  typedef struct packed {
    logic ovf;
    logic unf;
  } wrap_flags_t;

  // MODULO must lie in 2 .. 2**BITS.
  function automatic bit modulo_legal(input int unsigned bits, input longint unsigned modulo);
    return (modulo >= 64'd2) && (modulo <= (64'd1 << bits));
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every div+1 enabled cycles.
// Phase holds while ena is low; clr restarts the period.
module counter_prescaler #(
  parameter int PRE_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                clr,
  input  logic [PRE_BITS-1:0] div,
  output logic                tick
);

  logic [PRE_BITS-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = ena & (pre_cnt_q == div);

  // Next phase; a phase left beyond a shrunken div restarts at 0 without a tick.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (ena) begin
      if (pre_cnt_q >= div) begin
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  // Phase register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/modulo_updown_counter.sv
// Modulo-N up/down counter with prescaled count enable, synchronous clear/load
// (with clamp), combinational terminal count and registered wrap pulses.
module modulo_updown_counter
  import modulo_updown_counter_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int MODULO   = 2 ** BITS,
  parameter int PRE_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                clr,
  input  logic                load,
  input  logic [BITS-1:0]     load_val,
  input  logic                dir,
  input  logic [PRE_BITS-1:0] pre_div,
  output logic [BITS-1:0]     out,
  output logic                tc,
  output logic                ovf,
  output logic                unf
);

  if (BITS < 1 || PRE_BITS < 1) begin : gen_width_check
    $error("modulo_updown_counter: BITS and PRE_BITS must be >= 1");
  end
  if (!modulo_legal(BITS, MODULO)) begin : gen_modulo_check
    $error("modulo_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**BITS");
  end

  // One extra bit so MODULO = 2**BITS is representable for the load clamp.
  localparam logic [BITS:0]   ModuloW = (BITS + 1)'(MODULO);
  localparam logic [BITS-1:0] MaxVal  = BITS'(MODULO - 1);

  logic [BITS-1:0] count_q, count_d;
  wrap_flags_t     flags_q, flags_d;
  logic            tick;
  logic            at_top, at_bottom;

  // Load also restarts the prescale period.
  counter_prescaler #(
    .PRE_BITS(PRE_BITS)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .clr (clr | load),
    .div (pre_div),
    .tick(tick)
  );

  assign at_top    = (count_q == MaxVal);
  assign at_bottom = (count_q == '0);

  // Next count and wrap flags; priority clr > load > tick.
  always_comb begin
    count_d = count_q;
    flags_d = '0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = ({1'b0, load_val} >= ModuloW) ? MaxVal : load_val;
    end else if (tick) begin
      if (dir == DIR_DOWN) begin
        if (at_bottom) begin
          count_d     = MaxVal;
          flags_d.unf = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end else begin
        if (at_top) begin
          count_d     = '0;
          flags_d.ovf = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  // Count and flag registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      flags_q <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  // Terminal count is combinational so it can enable a cascaded stage this cycle.
  assign tc  = tick & ~clr & ~load & ((dir == DIR_UP) ? at_top : at_bottom);
  assign out = count_q;
  assign ovf = flags_q.ovf;
  assign unf = flags_q.unf;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Self-checking bench: a MODULO=10 and a MODULO=16 counter share one stimulus
// stream and are each compared against an arithmetic model every cycle.
module tb_modulo_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [1:0] pre_div = 2'd0;

  logic [3:0] out10, out16;
  logic       tc10, tc16, ovf10, ovf16, unf10, unf16;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int cnt;
    int pre;
    bit ovf;
    bit unf;
  } mstate_t;

  mstate_t m10, m16;

  modulo_updown_counter #(.BITS(4), .MODULO(10), .PRE_BITS(2)) dut10 (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .pre_div(pre_div), .out(out10), .tc(tc10), .ovf(ovf10), .unf(unf10)
  );

  modulo_updown_counter #(.BITS(4), .MODULO(16), .PRE_BITS(2)) dut16 (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .pre_div(pre_div), .out(out16), .tc(tc16), .ovf(ovf16), .unf(unf16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of one edge in plain modular arithmetic.
  function automatic mstate_t model_next(input int m, input mstate_t s);
    mstate_t n;
    int      div;
    div   = int'(pre_div);
    n     = s;
    n.ovf = 1'b0;
    n.unf = 1'b0;
    if (clr) begin
      n.cnt = 0;
      n.pre = 0;
    end else if (load) begin
      n.cnt = (int'(load_val) < m) ? int'(load_val) : m - 1;
      n.pre = 0;
    end else if (ena) begin
      n.pre = (s.pre >= div) ? 0 : s.pre + 1;
      if (s.pre == div) begin
        n.cnt = (s.cnt + (dir ? m - 1 : 1)) % m;
        n.ovf = !dir && (n.cnt == 0);
        n.unf = dir && (n.cnt == m - 1);
      end
    end
    return n;
  endfunction

  function automatic bit model_tc(input int m, input mstate_t s);
    return ena && (s.pre == int'(pre_div)) && !clr && !load &&
           (dir ? (s.cnt == 0) : (s.cnt == m - 1));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m10 <= '0;
      m16 <= '0;
    end else begin
      m10 <= model_next(10, m10);
      m16 <= model_next(16, m16);
    end
  end

  // Every-cycle comparison against the model, mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m10_out", int'(out10), m10.cnt);
      chk("m10_tc", int'(tc10), int'(model_tc(10, m10)));
      chk("m10_ovf", int'(ovf10), int'(m10.ovf));
      chk("m10_unf", int'(unf10), int'(m10.unf));
      chk("m16_out", int'(out16), m16.cnt);
      chk("m16_tc", int'(tc16), int'(model_tc(16, m16)));
      chk("m16_ovf", int'(ovf16), int'(m16.ovf));
      chk("m16_unf", int'(unf16), int'(m16.unf));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset without any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_out10", int'(out10), 0);
    chk("reset_out16", int'(out16), 0);
    chk("reset_ovf10", int'(ovf10), 0);
    chk("reset_unf10", int'(unf10), 0);
    step();
    step();
    rst = 1'b0;

    // Up wrap, tick every cycle.
    ena = 1'b1;
    pre_div = 2'd0;
    dir = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("up_out", int'(out10), i % 10);
      chk("up_ovf", int'(ovf10), (i == 10) ? 1 : 0);
      #1 chk("up_tc", int'(tc10), (i == 9) ? 1 : 0);
    end

    // Down wrap from a loaded 1.
    load = 1'b1;
    load_val = 4'd1;
    step();
    load = 1'b0;
    dir = 1'b1;
    chk("dn_load_out", int'(out10), 1);
    chk("dn_load_ovf", int'(ovf10), 0);
    #1 chk("dn_tc_at1", int'(tc10), 0);
    step();
    chk("dn_out0", int'(out10), 0);
    #1 chk("dn_tc_at0", int'(tc10), 1);
    step();
    chk("dn_out9", int'(out10), 9);
    chk("dn_unf", int'(unf10), 1);
    chk("dn_ovf", int'(ovf10), 0);
    chk("dn_out16", int'(out16), 15);
    step();
    chk("dn_out8", int'(out10), 8);
    chk("dn_unf_gone", int'(unf10), 0);

    // Prescaler with divide-by-3, hold, and a shrinking divider.
    dir = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    pre_div = 2'd2;
    chk("pre_clr_out", int'(out10), 0);
    step(); chk("pre_e1", int'(out10), 0);
    step(); chk("pre_e2", int'(out10), 0);
    step(); chk("pre_e3", int'(out10), 1);
    step(); chk("pre_e4", int'(out10), 1);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pre_hold", int'(out10), 1);
    end
    ena = 1'b1;
    step(); chk("pre_resume1", int'(out10), 1);
    step(); chk("pre_resume2", int'(out10), 2);
    step();
    step();
    pre_div = 2'd1;
    step(); chk("pre_shrink_notick", int'(out10), 2);
    step(); chk("pre_shrink_wait", int'(out10), 2);
    step(); chk("pre_shrink_tick", int'(out10), 3);

    // Priority and clamp.
    clr = 1'b1;
    load = 1'b1;
    load_val = 4'd5;
    step();
    chk("prio_out", int'(out10), 0);
    chk("prio_ovf", int'(ovf10), 0);
    chk("prio_unf", int'(unf10), 0);
    clr = 1'b0;
    load_val = 4'd12;
    step();
    chk("clamp_out10", int'(out10), 9);
    chk("clamp_out16", int'(out16), 12);
    chk("clamp_ovf", int'(ovf10), 0);
    pre_div = 2'd0;
    load_val = 4'd9;
    #1 chk("tc_masked_by_load", int'(tc10), 0);
    step();
    load = 1'b0;
    #1 chk("tc_at_top", int'(tc10), 1);

    // Reset mid-count and mid-prescale.
    pre_div = 2'd2;
    load = 1'b1;
    load_val = 4'd7;
    step();
    load = 1'b0;
    step();
    chk("rst_pre_out", int'(out10), 7);
    rst = 1'b1;
    #1;
    chk("rst_async_out10", int'(out10), 0);
    chk("rst_async_out16", int'(out16), 0);
    rst = 1'b0;
    step(); chk("rst_e1", int'(out10), 0);
    step(); chk("rst_e2", int'(out10), 0);
    step(); chk("rst_e3", int'(out10), 1);

    // Full-range wrap and reversal at the top.
    pre_div = 2'd0;
    load = 1'b1;
    load_val = 4'd15;
    step();
    load = 1'b0;
    chk("full_load16", int'(out16), 15);
    chk("full_load10", int'(out10), 9);
    #1 chk("full_tc16", int'(tc16), 1);
    step();
    chk("full_wrap16", int'(out16), 0);
    chk("full_ovf16", int'(ovf16), 1);
    chk("full_ovf10", int'(ovf10), 1);
    load = 1'b1;
    step();
    load = 1'b0;
    dir = 1'b1;
    #1 chk("rev_tc16", int'(tc16), 0);
    step();
    chk("rev_out16", int'(out16), 14);
    chk("rev_ovf16", int'(ovf16), 0);
    chk("rev_unf16", int'(unf16), 0);
    chk("rev_out10", int'(out10), 8);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
